// File: rtl/vend_pkg.sv
// Shared types and coin decode for the vending controller.
// Pure definitions: no logic, no latency, no flow control.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NICKEL  = 2'b00,
        DIME    = 2'b01,
        QUARTER = 2'b10,
        INVALID = 2'b11
    } coin_t;

    localparam logic [2:0] NICKEL_VAL = 3'd1;

    // Coin worth in nickels; INVALID is worth nothing.
    function automatic logic [2:0] coin_value(input coin_t c);
        case (c)
            NICKEL:  return NICKEL_VAL;
            DIME:    return 3'd2;
            QUARTER: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_acceptor.sv
// Coin decode and credit-ceiling check; purely combinational, same-cycle result.
// No backpressure: a coin is either credited (add_en) or rejected (reject).
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int CRED_W     = 5,
    parameter int MAX_CREDIT = 31
) (
    input  logic              coin_valid,
    input  logic [1:0]        coin_type,
    input  logic              accept_en,
    input  logic [CRED_W-1:0] credit,
    output logic              add_en,
    output logic [CRED_W-1:0] add_val,
    output logic              reject
);

    logic [2:0]      val;
    logic [CRED_W:0] sum;
    logic            bad;

    // One extra bit on the sum so a near-full credit cannot wrap past the ceiling.
    always_comb begin
        val     = coin_value(coin_t'(coin_type));
        sum     = {1'b0, credit} + (CRED_W+1)'(val);
        bad     = (coin_t'(coin_type) == INVALID) || (sum > (CRED_W+1)'(MAX_CREDIT));
        add_en  = coin_valid && accept_en && !bad;
        add_val = CRED_W'(val);
        reject  = coin_valid && !(accept_en && !bad);
    end

endmodule

// File: rtl/vend_controller.sv
// Vending FSM: credit accumulation, vend handshake, nickel-per-cycle change; all outputs registered.
// vend_go held until vend_done; optional coin_return input when COIN_RETURN_EN is defined.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 31,
    parameter int CRED_W     = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              coin_valid,
    input  logic [1:0]        coin_type,
    input  logic              vend_req,
    input  logic              vend_done,
`ifdef COIN_RETURN_EN
    input  logic              coin_return,
`endif
    output logic              vend_go,
    output logic              coin_reject,
    output logic              change_pulse,
    output logic [3:0]        change_code,
    output logic [CRED_W-1:0] credit,
    output logic              busy
);

    localparam logic [CRED_W-1:0] PRICE_C = CRED_W'(PRICE);

    state_t            state_q, state_d;
    logic [CRED_W-1:0] credit_q, credit_d;
    logic [3:0]        code_q, code_d;
    logic              reject_q, reject_d;
    logic              vend_go_q, pulse_q, busy_q;
    logic              add_en, coin_rej, accept_en;
    logic [CRED_W-1:0] add_val;

    function automatic logic [3:0] sat15(input logic [CRED_W-1:0] c);
        return (c > CRED_W'(15)) ? 4'hF : 4'(c);
    endfunction

    assign accept_en = (state_q == IDLE) || (state_q == CREDIT);

    coin_acceptor #(
        .CRED_W     (CRED_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_coin (
        .coin_valid (coin_valid),
        .coin_type  (coin_type),
        .accept_en  (accept_en),
        .credit     (credit_q),
        .add_en     (add_en),
        .add_val    (add_val),
        .reject     (coin_rej)
    );

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        code_d   = code_q;
        reject_d = coin_rej;
        case (state_q)
            IDLE, CREDIT: begin
                // A coin in the same cycle always wins; vend_req is a level and retries.
                if (add_en) begin
                    credit_d = credit_q + add_val;
                    code_d   = 4'd0;
                    state_d  = CREDIT;
                end else if (state_q == CREDIT && !coin_valid && vend_req
                             && credit_q >= PRICE_C) begin
                    credit_d = credit_q - PRICE_C;
                    state_d  = VEND;
                end
`ifdef COIN_RETURN_EN
                else if (state_q == CREDIT && !coin_valid && coin_return) begin
                    code_d  = sat15(credit_q);
                    state_d = CHANGE;
                end
`endif
            end
            VEND: begin
                if (vend_done) begin
                    code_d  = sat15(credit_q);
                    state_d = (credit_q != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                credit_d = credit_q - CRED_W'(NICKEL_VAL);
                if (credit_q <= CRED_W'(NICKEL_VAL)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            credit_q  <= '0;
            code_q    <= '0;
            reject_q  <= 1'b0;
            vend_go_q <= 1'b0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            code_q    <= code_d;
            reject_q  <= reject_d;
            vend_go_q <= (state_d == VEND);
            pulse_q   <= (state_d == CHANGE);
            busy_q    <= (state_d == VEND) || (state_d == CHANGE);
        end
    end

    assign vend_go      = vend_go_q;
    assign coin_reject  = reject_q;
    assign change_pulse = pulse_q;
    assign change_code  = code_q;
    assign credit       = credit_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: a transaction-level model predicts each cycle's outputs.
// Driver pushes predictions at the falling edge; a monitor pops and compares after the rising edge.
module tb_vend_controller;

    localparam int PRICE      = 15;
    localparam int MAX_CREDIT = 31;
    localparam int CRED_W     = 5;

    typedef struct packed {
        logic       vend_go;
        logic       coin_reject;
        logic       change_pulse;
        logic [3:0] change_code;
        logic [4:0] credit;
        logic       busy;
    } obs_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              coin_valid = 1'b0;
    logic [1:0]        coin_type = 2'b00;
    logic              vend_req = 1'b0;
    logic              vend_done = 1'b0;
`ifdef COIN_RETURN_EN
    logic              coin_return = 1'b0;
`endif
    logic              vend_go, coin_reject, change_pulse, busy;
    logic [3:0]        change_code;
    logic [CRED_W-1:0] credit;

    int    n_pass = 0;
    int    n_total = 0;
    obs_t  exp_q[$];
    string phase = "reset";

    // Model: 0 = taking coins, 1 = dispensing, 2 = paying change.
    int m_mode = 0;
    int m_credit = 0;
    int m_code = 0;

    always #5 clk = ~clk;

    vend_controller #(
        .PRICE      (PRICE),
        .MAX_CREDIT (MAX_CREDIT),
        .CRED_W     (CRED_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .vend_req     (vend_req),
        .vend_done    (vend_done),
`ifdef COIN_RETURN_EN
        .coin_return  (coin_return),
`endif
        .vend_go      (vend_go),
        .coin_reject  (coin_reject),
        .change_pulse (change_pulse),
        .change_code  (change_code),
        .credit       (credit),
        .busy         (busy)
    );

    function automatic obs_t sample();
        obs_t o;
        o.vend_go      = vend_go;
        o.coin_reject  = coin_reject;
        o.change_pulse = change_pulse;
        o.change_code  = change_code;
        o.credit       = credit;
        o.busy         = busy;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got go=%b rej=%b pulse=%b code=%0d credit=%0d busy=%b, want go=%b rej=%b pulse=%b code=%0d credit=%0d busy=%b",
                      name, act.vend_go, act.coin_reject, act.change_pulse, act.change_code,
                      act.credit, act.busy, exp.vend_go, exp.coin_reject, exp.change_pulse,
                      exp.change_code, exp.credit, exp.busy);
    endtask

    // One cycle of stimulus plus the predicted outputs after the next rising edge.
    task automatic cyc(input bit cv, input logic [1:0] ct, input bit vr, input bit vd, input bit cr);
        int   v;
        bit   rej;
        obs_t e;
        @(negedge clk);
        coin_valid = cv;
        coin_type  = ct;
        vend_req   = vr;
        vend_done  = vd;
`ifdef COIN_RETURN_EN
        coin_return = cr;
`endif
        rej = 1'b0;
        v = (ct == 2'd0) ? 1 : (ct == 2'd1) ? 2 : (ct == 2'd2) ? 5 : 0;
        if (m_mode == 0) begin
            if (cv) begin
                if (ct == 2'd3 || m_credit + v > MAX_CREDIT) rej = 1'b1;
                else begin
                    m_credit += v;
                    m_code = 0;
                end
            end else if (vr && m_credit >= PRICE) begin
                m_credit -= PRICE;
                m_mode = 1;
            end else if (cr && m_credit > 0) begin
`ifdef COIN_RETURN_EN
                m_code = (m_credit > 15) ? 15 : m_credit;
                m_mode = 2;
`endif
            end
        end else begin
            if (cv) rej = 1'b1;
            if (m_mode == 1) begin
                if (vd) begin
                    m_code = (m_credit > 15) ? 15 : m_credit;
                    m_mode = (m_credit > 0) ? 2 : 0;
                end
            end else begin
                m_credit -= 1;
                if (m_credit == 0) m_mode = 0;
            end
        end
        e.vend_go      = (m_mode == 1);
        e.coin_reject  = rej;
        e.change_pulse = (m_mode == 2);
        e.change_code  = 4'(m_code);
        e.credit       = 5'(m_credit);
        e.busy         = (m_mode != 0);
        exp_q.push_back(e);
    endtask

    task automatic coin(input logic [1:0] ct);
        cyc(1'b1, ct, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        reset_n    = 1'b0;
        coin_valid = 1'b0;
        vend_req   = 1'b0;
        vend_done  = 1'b0;
        #1;
        check("async_reset_mid_change", sample(), '0);
        m_mode = 0;
        m_credit = 0;
        m_code = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check(phase, sample(), exp_q.pop_front());
        end
    end

    initial begin
        bit          r_cv, r_vd, r_cr, r_vr;
        logic [1:0]  r_ct;
        #2;
        check("reset_state", sample(), '0);
        @(negedge clk);
        reset_n = 1'b1;

        phase = "vend_with_change";
        coin(2'd1); coin(2'd2); coin(2'd2); coin(2'd0); coin(2'd2);
        cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        idle(2);
        cyc(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(5);

        phase = "exact_vend";
        coin(2'd2); coin(2'd2); coin(2'd2);
        cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(3);

        phase = "ceiling";
        for (int i = 0; i < 6; i++) coin(2'd2);
        coin(2'd1); coin(2'd0); coin(2'd3);
        cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(18);

        phase = "deferred_vend";
        coin(2'd2); coin(2'd2);
        cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        idle(1);
        coin(2'd2);
        cyc(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(3);

        phase = "reset_mid_change";
        for (int i = 0; i < 6; i++) coin(2'd2);
        cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(3);
        mid_reset();
        coin(2'd1);
        idle(2);

`ifdef COIN_RETURN_EN
        phase = "coin_return";
        coin(2'd2); coin(2'd1);
        cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        idle(9);
`endif

        phase = "random";
        r_vr = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            r_cv = ($urandom_range(9) < 3);
            r_ct = 2'($urandom_range(3));
            if ($urandom_range(9) == 0) r_vr = ~r_vr;
            r_vd = ($urandom_range(4) == 0);
            r_cr = !r_cv && ($urandom_range(19) == 0);
            cyc(r_cv, r_ct, r_vr, r_vd, r_cr);
        end
        idle(40);

        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
